// File: rtl/sort_pkg.sv
// Shared types and width helpers for the sort stream adapter.
package sort_pkg;

  // Adapter phases: collect a frame, wait on the engine, replay the result.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } adapter_state_t;

  // Width of a counter that indexes n items (never narrower than 1 bit).
  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a packed frame of n words of w bits each.
  function automatic int frame_w(input int n, input int w);
    return n * w;
  endfunction

  localparam int DEF_NUM_VALS  = 5;
  localparam int DEF_SIZE_DATA = 8;
  localparam int DEF_LANE_W    = lane_idx_w(DEF_NUM_VALS);
  localparam int DEF_FRAME_W   = frame_w(DEF_NUM_VALS, DEF_SIZE_DATA);

endpackage

// File: rtl/sort_stream_adapter.sv
// Stream-to-engine wrapper: gathers NUM_VALS words into a packed frame,
// hands it to the sort engine with a level start, waits for done (with a
// timeout), then replays the sorted lanes as a valid/ready stream.
module sort_stream_adapter
  import sort_pkg::*;
#(
  parameter int NUM_VALS    = 5,
  parameter int SIZE_DATA   = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_s_valid,
  input  logic [SIZE_DATA-1:0]            i_s_data,
  output logic                            o_s_ready,
  output logic                            o_m_valid,
  output logic [SIZE_DATA-1:0]            o_m_data,
  output logic                            o_m_last,
  input  logic                            i_m_ready,
  output logic                            o_sort_start,
  output logic [NUM_VALS*SIZE_DATA-1:0]   o_sort_data,
  input  logic                            i_sort_done,
  input  logic [NUM_VALS*SIZE_DATA-1:0]   i_sort_data,
  output logic                            o_busy,
  output logic                            o_err
);

  localparam int                LANE_W    = lane_idx_w(NUM_VALS);
  localparam int                TMO_W     = lane_idx_w(TIMEOUT_CYC);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_VALS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  adapter_state_t       state_q, state_d;
  logic [LANE_W-1:0]    cnt_q;
  logic [LANE_W-1:0]    idx_q;
  logic [TMO_W-1:0]     tmo_q;
  logic [SIZE_DATA-1:0] frame_q  [NUM_VALS];
  logic [SIZE_DATA-1:0] result_q [NUM_VALS];
  logic                 s_ready_q;
  logic                 err_q;

  logic s_fire, fill_done, sort_ok, tmo_hit, m_fire, drain_done;

  // Ready is only ever high in FILL, so an accepted word implies FILL.
  assign s_fire     = i_s_valid & s_ready_q;
  assign fill_done  = s_fire && (cnt_q == LAST_LANE);
  // Done only counts while waiting on the engine; stray pulses are ignored.
  assign sort_ok    = (state_q == SORT) && i_sort_done;
  // A done on the final cycle beats the timeout.
  assign tmo_hit    = (state_q == SORT) && !i_sort_done && (tmo_q == TMO_LAST);
  assign m_fire     = (state_q == DRAIN) && i_m_ready;
  assign drain_done = m_fire && (idx_q == LAST_LANE);

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the edge regardless of block order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= FILL;
    else          state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (fill_done)  state_d = SORT;
      SORT:    if (sort_ok)    state_d = DRAIN;
               else if (tmo_hit) state_d = FILL;
      DRAIN:   if (drain_done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Counters, frame/result registers, ready flag and error pulse.
  // NOTE: the frame and result arrays are small flop banks, not RAM, and are
  // reset so that o_sort_data and o_m_data read zero straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      s_ready_q <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < NUM_VALS; k++) begin
        frame_q[k]  <= '0;
        result_q[k] <= '0;
      end
    end else begin
      s_ready_q <= (state_d == FILL);
      err_q     <= tmo_hit;
      case (state_q)
        FILL: begin
          tmo_q <= '0;
          if (s_fire) begin
            frame_q[cnt_q] <= i_s_data;
            cnt_q          <= fill_done ? '0 : cnt_q + 1'b1;
          end
        end
        SORT: begin
          tmo_q <= tmo_q + 1'b1;
          if (sort_ok) begin
            idx_q <= '0;
            for (int k = 0; k < NUM_VALS; k++)
              result_q[k] <= i_sort_data[k*SIZE_DATA +: SIZE_DATA];
          end
          if (tmo_hit) cnt_q <= '0;
        end
        DRAIN: begin
          if (m_fire) idx_q <= drain_done ? '0 : idx_q + 1'b1;
        end
        default: begin
          cnt_q <= '0;
          idx_q <= '0;
        end
      endcase
    end
  end

  // Present the frame to the engine, lane k at bits [k*SIZE_DATA +: SIZE_DATA].
  for (genvar k = 0; k < NUM_VALS; k++) begin : g_pack
    assign o_sort_data[k*SIZE_DATA +: SIZE_DATA] = frame_q[k];
  end

  assign o_s_ready    = s_ready_q;
  assign o_sort_start = (state_q == SORT);
  assign o_busy       = (state_q != FILL);
  assign o_m_valid    = (state_q == DRAIN);
  assign o_m_last     = o_m_valid && (idx_q == LAST_LANE);
  assign o_m_data     = o_m_valid ? result_q[idx_q] : '0;
  assign o_err        = err_q;

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Directed bench for sort_stream_adapter; the engine is modelled by hand
// with fixed done timing and hand-sorted results.
module tb_sort_stream_adapter;

  typedef logic [7:0] words_t [5];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic        sort_start;
  logic [39:0] sort_data;
  logic        sort_done;
  logic [39:0] sort_res;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  sort_stream_adapter #(
    .NUM_VALS    (5),
    .SIZE_DATA   (8),
    .TIMEOUT_CYC (256)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_s_valid    (s_valid),
    .i_s_data     (s_data),
    .o_s_ready    (s_ready),
    .o_m_valid    (m_valid),
    .o_m_data     (m_data),
    .o_m_last     (m_last),
    .i_m_ready    (m_ready),
    .o_sort_start (sort_start),
    .o_sort_data  (sort_data),
    .i_sort_done  (sort_done),
    .i_sort_data  (sort_res),
    .o_busy       (busy),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Feed five words, `gap` idle cycles between them; optionally pulse a stray
  // done right after word index `stray_after` has been accepted.
  task automatic send_frame(input words_t w, input int gap, input int stray_after,
                            input logic [39:0] exp_packed);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      if (i == 4) check("start_low_before_last", sort_start, 1'b0);
      check("s_ready_fill", s_ready, 1'b1);
      s_valid = 1'b1;
      s_data  = w[i];
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = '0;
      if (i == stray_after) begin
        sort_done = 1'b1;
        sort_res  = 40'hEEEE_EEEE_EE;
        @(negedge clk);
        sort_done = 1'b0;
        sort_res  = '0;
        check("stray_done_busy", busy, 1'b0);
        check("stray_done_ready", s_ready, 1'b1);
      end
    end
    check("start_after_fill", sort_start, 1'b1);
    check("sort_data", sort_data, exp_packed);
    check("s_ready_in_sort", s_ready, 1'b0);
    check("busy_in_sort", busy, 1'b1);
  endtask

  // Hold off for `delay` cycles, then return the sorted bus with a done pulse.
  task automatic engine_done(input int delay, input logic [39:0] held, input logic [39:0] sorted);
    repeat (delay) @(negedge clk);
    check("start_held", sort_start, 1'b1);
    check("sort_data_held", sort_data, held);
    sort_done = 1'b1;
    sort_res  = sorted;
    @(negedge clk);
    sort_done = 1'b0;
    sort_res  = '0;
    check("start_dropped", sort_start, 1'b0);
    check("m_valid_after_done", m_valid, 1'b1);
  endtask

  // Drain five words; with `stall` the ready pattern is 1,0,0,1 repeating.
  task automatic drain(input words_t e, input bit stall);
    int k = 0;
    int p = 0;
    while (k < 5 && p < 60) begin
      check("m_valid", m_valid, 1'b1);
      check("m_data", m_data, e[k]);
      check("m_last", m_last, (k == 4));
      m_ready = stall ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
      if (m_ready) k++;
      p++;
      @(negedge clk);
    end
    m_ready = 1'b0;
    check("drain_words", k, 5);
    check("m_valid_after_drain", m_valid, 1'b0);
    check("s_ready_after_drain", s_ready, 1'b1);
    check("busy_after_drain", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    words_t f1, s1, f2, s2;
    int n;
    f1 = '{8'h05, 8'h03, 8'h09, 8'h01, 8'h07};
    s1 = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h09};
    f2 = '{8'h02, 8'h02, 8'h00, 8'hFF, 8'h10};
    s2 = '{8'h00, 8'h02, 8'h02, 8'h10, 8'hFF};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    sort_done = 1'b0; sort_res = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_start", sort_start, 1'b0);
    check("rst_sort_data", sort_data, 40'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1'b1);

    // Back-to-back frame, free-flowing output.
    send_frame(f1, 0, -1, 40'h0701090305);
    engine_done(30, 40'h0701090305, 40'h0907050301);
    drain(s1, 1'b0);

    // Same frame with a stalling consumer.
    send_frame(f1, 0, -1, 40'h0701090305);
    engine_done(5, 40'h0701090305, 40'h0907050301);
    drain(s1, 1'b1);

    // One word every third cycle.
    send_frame(f1, 2, -1, 40'h0701090305);
    engine_done(8, 40'h0701090305, 40'h0907050301);
    drain(s1, 1'b0);

    // Engine never answers: timeout, then a fresh frame.
    send_frame(f1, 0, -1, 40'h0701090305);
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycle", n, 256);
    check("timeout_start_low", sort_start, 1'b0);
    check("timeout_ready", s_ready, 1'b1);
    @(negedge clk);
    check("err_is_pulse", err, 1'b0);
    send_frame(f2, 0, -1, 40'h10FF000202);
    engine_done(10, 40'h10FF000202, 40'hFF10020200);
    drain(s2, 1'b0);

    // Reset while two words have already been drained.
    send_frame(f2, 0, -1, 40'h10FF000202);
    engine_done(4, 40'h10FF000202, 40'hFF10020200);
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    m_ready = 1'b0;
    check("mid_drain_data", m_data, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", m_valid, 1'b0);
    check("async_rst_m_data", m_data, 8'h00);
    check("async_rst_m_last", m_last, 1'b0);
    check("async_rst_start", sort_start, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_ready", s_ready, 1'b0);
    check("async_rst_sort_data", sort_data, 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst2", s_ready, 1'b1);
    send_frame(f1, 0, -1, 40'h0701090305);
    engine_done(6, 40'h0701090305, 40'h0907050301);
    drain(s1, 1'b0);

    // Stray done during FILL after two words.
    send_frame(f1, 0, 1, 40'h0701090305);
    engine_done(3, 40'h0701090305, 40'h0907050301);
    drain(s1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sort_stream_adapter.md
Name: sort_stream_adapter

Overview:
- Front-end/back-end wrapper that drives the packed-bus sort engine (insertionSort start/done interface) from the initiator side.
- Collects NUM_VALS words from a valid/ready input stream into a packed frame, issues start to the engine, waits for done, captures the sorted bus and replays it as a valid/ready output stream with a last marker.
- Sits between a serial sample producer and the sort engine. The engine is instantiated alongside it at the parent level.

Parameters:
- NUM_VALS, 5, words per frame (>=2)
- SIZE_DATA, 8, bits per word
- TIMEOUT_CYC, 256, max cycles to wait for engine done before aborting the frame (>=NUM_VALS*NUM_VALS+8)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_s_valid  in  1  input word valid
- i_s_data  in  SIZE_DATA  input word
- o_s_ready  out  1  adapter accepts input word
- o_m_valid  out  1  output word valid
- o_m_data  out  SIZE_DATA  output word, ascending order
- o_m_last  out  1  marks final word (lane NUM_VALS-1) of frame
- i_m_ready  in  1  downstream accepts output word
- o_sort_start  out  1  start request to engine (level)
- o_sort_data  out  NUM_VALS*SIZE_DATA  packed frame to engine, lane k at [k*SIZE_DATA +: SIZE_DATA]
- i_sort_done  in  1  engine done, single-cycle pulse
- i_sort_data  in  NUM_VALS*SIZE_DATA  packed sorted result, valid in the cycle i_sort_done=1
- o_busy  out  1  high in SORT or DRAIN
- o_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: state=FILL, lane count=0, o_s_ready=0 during reset and 1 in the first cycle after. o_m_valid, o_m_last, o_sort_start, o_busy and o_err are 0. o_sort_data, o_m_data and the result register are 0.
- FILL:
  - o_s_ready=1. A word is accepted on i_s_valid&o_s_ready and written to lane cnt of the frame register; cnt increments.
  - The accept that fills lane NUM_VALS-1 moves the block to SORT on the same edge and clears cnt. o_sort_start=1 from the next cycle.
  - Gaps in i_s_valid are allowed. Lane order is arrival order.
- SORT:
  - o_s_ready=0. o_sort_start is held 1 and o_sort_data is held stable.
  - A timeout counter increments each cycle.
  - When i_sort_done=1, the block captures i_sort_data into the result register, drops o_sort_start on the next edge and enters DRAIN. o_m_valid=1 in the cycle after done.
  - Start is low at least 2 cycles before the engine can return to its wait state, so no double sort.
- Timeout:
  - If the counter reaches TIMEOUT_CYC-1 without done, o_err pulses 1 cycle, o_sort_start drops, the frame is discarded and the block returns to FILL.
  - A done arriving in the same cycle as the timeout wins; no error is raised.
- DRAIN:
  - o_m_data = result lane idx. o_m_valid=1, o_m_last=(idx==NUM_VALS-1).
  - idx increments on i_m_valid-ready handshake (o_m_valid&i_m_ready).
  - o_m_data and o_m_last are held stable while i_m_ready=0.
  - The handshake on the last lane clears idx and returns the block to FILL; o_s_ready=1 the next cycle.
- Throughput: one word per cycle on each stream. No overlap of fill with sort/drain.
- Reset mid-operation: state and counters return to reset values immediately (async). A partial frame is lost. o_sort_start drops asynchronously.
- A stray i_sort_done outside SORT is ignored.
- Counters are sized $clog2(NUM_VALS) and $clog2(TIMEOUT_CYC). No wrap: cnt and idx saturate by the state transition.

Decomposition:
- Package sort_pkg holds:
  - the adapter_state_t enum {FILL, SORT, DRAIN}
  - localparam helpers for lane-index width and frame width (NUM_VALS*SIZE_DATA)
- No sub-module: single FSM plus frame/result registers.
- The sort engine is a sibling instance in the parent, not instantiated inside the adapter.

Test Plan:
- Input 05,03,09,01,07 back-to-back -> o_sort_data=40'h0701090305 with o_sort_start=1. Engine model returns done after 30 cycles with 40'h0907050301 -> output 01,03,05,07,09 on consecutive cycles, o_m_last only with 09, o_s_ready=1 the cycle after.
- Same frame with i_m_ready toggling 1,0,0,1 -> every word emitted exactly once, data/last stable while stalled, no drops or repeats.
- Input with valid gaps (one word every 3 cycles) -> identical packed frame, start asserted only after the 5th accept.
- Engine model never asserts done -> o_err pulse at cycle TIMEOUT_CYC after start. o_sort_start=0 and o_s_ready=1 next cycle. A new frame 02,02,00,FF,10 is then sorted correctly to 00,02,02,10,FF.
- i_rst_n low during DRAIN after 2 words -> all outputs 0 immediately. After release, a fresh 5-word frame completes normally with no leftover words.
- i_sort_done pulsed during FILL with 2 words loaded -> ignored: no capture, cnt continues, frame completes correctly.
